// File: rtl/uart_tx_buffered.sv
// UART transmitter with built-in 16x baud tick generator and a one-word holding register.
// Frames are start / DBIT data (LSB first) / optional parity / stop, sent back-to-back when queued.
module uart_tx_buffered #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PAR_EN  = 0,
  parameter int PAR_ODD = 0,
  parameter int DVSR_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              wr,
  input  logic [DBIT-1:0]   din,
  output logic              full,
  output logic              tx,
  output logic              tx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic PAR_ODD_BIT = (PAR_ODD != 0);

  state_t            state, state_next;
  logic [DVSR_W-1:0] cnt, cnt_next;
  logic              tick;
  logic [5:0]        s, s_next;
  logic [3:0]        n, n_next;
  logic [DBIT-1:0]   hold, shift, shift_next;
  logic              par_bit;
  logic              load;
  logic              tx_next;

  // Tick generator: >= rather than == so a divisor lowered mid-frame cannot stall the counter.
  always_comb begin
    tick     = (state != IDLE) && (cnt >= dvsr);
    cnt_next = cnt + 1'b1;
    if (state == IDLE || tick)
      cnt_next = '0;
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    shift_next = shift;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (full) begin
          load       = 1'b1;
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == 6'd15) begin
            state_next = DATA;
            s_next     = '0;
            n_next     = '0;
          end else begin
            s_next = s + 6'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == 6'd15) begin
            s_next     = '0;
            shift_next = shift >> 1;
            if (n == 4'(DBIT - 1))
              state_next = (PAR_EN != 0) ? PARITY : STOP;
            else
              n_next = n + 4'd1;
          end else begin
            s_next = s + 6'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (s == 6'd15) begin
            state_next = STOP;
            s_next     = '0;
          end else begin
            s_next = s + 6'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == 6'(SB_TICK - 1)) begin
            s_next = '0;
            // A queued word starts on the very edge that ends the stop bit.
            if (full) begin
              load       = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + 6'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (load)
      shift_next = hold;
  end

  // tx is registered from the next state so the line changes on the same edge as the FSM.
  always_comb begin
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_bit;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      s       <= '0;
      n       <= '0;
      full    <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      s       <= s_next;
      n       <= n_next;
      tx      <= tx_next;
      tx_busy <= (state_next != IDLE);
      if (load)
        full <= 1'b0;
      else if (wr && !full)
        full <= 1'b1;
    end
  end

  // Parity is computed from the holding word as it is loaded, before the shifter consumes it.
  always_ff @(posedge clk) begin
    shift <= shift_next;
    if (wr && !full)
      hold <= din;
    if (load)
      par_bit <= (^hold) ^ PAR_ODD_BIT;
  end

endmodule
